// File: rtl/img_win_ctrl.sv
// img_win_ctrl: loads a W x H image from ROM into an internal buffer, then applies
// 2x2-window commands (shift, max, min, average, rotate, optional mirror) around an
// operation point and finally streams the whole buffer out to RAM.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd, cmd_valid      command code and strobe (accepted only while busy=0)
//   IROM_Q/rd/A         ROM read port; data valid one cycle after its address
//   IRAM_valid/D/A      RAM write port
//   busy, done          command not accepted / image fully written
//
// Configuration: define IMG_WIN_CTRL_MIRROR_EN to enable MirrorX (10) and MirrorY (11);
// without it those codes are NOPs.
module img_win_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned WL = 3,
  parameter int unsigned HL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  input  logic [DW-1:0]    IROM_Q,
  output logic             IROM_rd,
  output logic [WL+HL-1:0] IROM_A,
  output logic             IRAM_valid,
  output logic [DW-1:0]    IRAM_D,
  output logic [WL+HL-1:0] IRAM_A,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW   = WL + HL;
  localparam int unsigned NPix = 1 << AW;

  localparam logic [AW:0]   LoadEnd  = (AW+1)'(NPix);
  localparam logic [AW:0]   WriteEnd = (AW+1)'(NPix - 1);
  localparam logic [WL-1:0] XInit    = WL'(1 << (WL - 1));
  localparam logic [HL-1:0] YInit    = HL'(1 << (HL - 1));
  localparam logic [WL-1:0] XMin     = WL'(1);
  localparam logic [HL-1:0] YMin     = HL'(1);
  localparam logic [WL-1:0] XMax     = WL'((1 << WL) - 1);
  localparam logic [HL-1:0] YMax     = HL'((1 << HL) - 1);

  localparam logic [3:0] CmdWrite = 4'd0;
  localparam logic [3:0] CmdUp    = 4'd1;
  localparam logic [3:0] CmdDown  = 4'd2;
  localparam logic [3:0] CmdLeft  = 4'd3;
  localparam logic [3:0] CmdRight = 4'd4;
  localparam logic [3:0] CmdMax   = 4'd5;
  localparam logic [3:0] CmdMin   = 4'd6;
  localparam logic [3:0] CmdAvg   = 4'd7;
  localparam logic [3:0] CmdCcw   = 4'd8;
  localparam logic [3:0] CmdCw    = 4'd9;
  localparam logic [3:0] CmdMirX  = 4'd10;
  localparam logic [3:0] CmdMirY  = 4'd11;

  typedef enum logic [2:0] {StLoad, StIdle, StExec, StWrite, StFin} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;       // load cycle / write address counter
  logic [WL-1:0] px_q, px_d;
  logic [HL-1:0] py_q, py_d;
  logic [3:0]    cmd_q, cmd_d;

  logic [DW-1:0] mem_q [NPix];

  logic          ld_we, win_we, win_op;
  logic [AW-1:0] ld_idx;
  logic [AW-1:0] tl_idx, tr_idx, bl_idx, br_idx;
  logic [DW-1:0] tl_p, tr_p, bl_p, br_p;
  logic [DW-1:0] tl_n, tr_n, bl_n, br_n;
  logic [DW+1:0] win_sum;
  logic [DW-1:0] win_max, win_min;

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Buffer index y*W+x is simply the concatenation {y, x}.
  assign tl_idx = {py_q - YMin, px_q - XMin};
  assign tr_idx = {py_q - YMin, px_q};
  assign bl_idx = {py_q, px_q - XMin};
  assign br_idx = {py_q, px_q};

  assign tl_p = mem_q[tl_idx];
  assign tr_p = mem_q[tr_idx];
  assign bl_p = mem_q[bl_idx];
  assign br_p = mem_q[br_idx];

  // ROM data arriving this cycle belongs to the address issued last cycle.
  assign ld_idx = cnt_q[AW-1:0] - AW'(1);

  assign win_sum = (DW+2)'(tl_p) + (DW+2)'(tr_p) + (DW+2)'(bl_p) + (DW+2)'(br_p);
  assign win_max = max2(max2(tl_p, tr_p), max2(bl_p, br_p));
  assign win_min = min2(min2(tl_p, tr_p), min2(bl_p, br_p));

  // Window result for the latched command.
  always_comb begin
    win_op = 1'b0;
    tl_n   = tl_p;
    tr_n   = tr_p;
    bl_n   = bl_p;
    br_n   = br_p;
    case (cmd_q)
      CmdMax: begin
        win_op = 1'b1;
        tl_n = win_max; tr_n = win_max; bl_n = win_max; br_n = win_max;
      end
      CmdMin: begin
        win_op = 1'b1;
        tl_n = win_min; tr_n = win_min; bl_n = win_min; br_n = win_min;
      end
      CmdAvg: begin
        win_op = 1'b1;
        tl_n = win_sum[DW+1:2]; tr_n = win_sum[DW+1:2];
        bl_n = win_sum[DW+1:2]; br_n = win_sum[DW+1:2];
      end
      CmdCcw: begin
        win_op = 1'b1;
        tl_n = tr_p; tr_n = br_p; br_n = bl_p; bl_n = tl_p;
      end
      CmdCw: begin
        win_op = 1'b1;
        tl_n = bl_p; bl_n = br_p; br_n = tr_p; tr_n = tl_p;
      end
`ifdef IMG_WIN_CTRL_MIRROR_EN
      CmdMirX: begin
        win_op = 1'b1;
        tl_n = bl_p; bl_n = tl_p; tr_n = br_p; br_n = tr_p;
      end
      CmdMirY: begin
        win_op = 1'b1;
        tl_n = tr_p; tr_n = tl_p; bl_n = br_p; br_n = bl_p;
      end
`else
      CmdMirX, CmdMirY: win_op = 1'b0;
`endif
      default: win_op = 1'b0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    px_d       = px_q;
    py_d       = py_q;
    cmd_d      = cmd_q;
    ld_we      = 1'b0;
    win_we     = 1'b0;
    IROM_rd    = 1'b0;
    IROM_A     = '0;
    IRAM_valid = 1'b0;
    IRAM_A     = '0;
    IRAM_D     = '0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      StLoad: begin
        // Cycles 0..N-1 issue addresses; cycle N only stores the last pixel.
        IROM_rd = (cnt_q < LoadEnd);
        IROM_A  = cnt_q[AW-1:0];
        ld_we   = (cnt_q != '0);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LoadEnd) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        busy = 1'b0;
        if (cmd_valid) begin
          cmd_d   = cmd;
          state_d = StExec;
        end
      end
      StExec: begin
        win_we = win_op;
        case (cmd_q)
          CmdUp:    if (py_q != YMin) py_d = py_q - YMin;
          CmdDown:  if (py_q != YMax) py_d = py_q + YMin;
          CmdLeft:  if (px_q != XMin) px_d = px_q - XMin;
          CmdRight: if (px_q != XMax) px_d = px_q + XMin;
          default:  ;
        endcase
        cnt_d   = '0;
        state_d = (cmd_q == CmdWrite) ? StWrite : StIdle;
      end
      StWrite: begin
        IRAM_valid = 1'b1;
        IRAM_A     = cnt_q[AW-1:0];
        IRAM_D     = mem_q[cnt_q[AW-1:0]];
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == WriteEnd) state_d = StFin;
      end
      StFin: begin
        done = 1'b1;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      px_q    <= XInit;
      py_q    <= YInit;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cmd_q   <= cmd_d;
    end
  end

  // Image buffer: no reset, always reloaded after reset.
  always_ff @(posedge clk) begin
    if (!reset && ld_we) begin
      mem_q[ld_idx] <= IROM_Q;
    end
    if (!reset && win_we) begin
      mem_q[tl_idx] <= tl_n;
      mem_q[tr_idx] <= tr_n;
      mem_q[bl_idx] <= bl_n;
      mem_q[br_idx] <= br_n;
    end
  end

endmodule

// File: tb/tb_img_win_ctrl.sv
// Self-checking bench for img_win_ctrl: directed scenarios plus randomized command
// streams, compared against a behavioural image/window model.
module tb_img_win_ctrl;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] IROM_Q;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom [N];
  int         img [N];
  int         got [N];
  int         px, py;

  img_win_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_Q     (IROM_Q),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge clk) IROM_Q <= rom[IROM_A];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reset, follow the full ROM load, then mirror the image in the model.
  task automatic do_load();
    int k;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_rd", IROM_rd, 1);
    check_eq("rst_rom_a", IROM_A, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_ram_valid", IRAM_valid, 0);
    check_eq("rst_ram_a", IRAM_A, 0);
    check_eq("rst_ram_d", IRAM_D, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_eq("ld_addr", IROM_A, i);
      check_eq("ld_rd", IROM_rd, 1);
      @(negedge clk);
    end
    k = 0;
    while (busy !== 1'b0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check_eq("ld_to_idle", busy, 0);
    check_eq("idle_rd", IROM_rd, 0);
    for (int i = 0; i < N; i++) img[i] = rom[i];
    px = W / 2;
    py = H / 2;
  endtask

  // Behavioural effect of one accepted command on the image model.
  task automatic model_cmd(input int c);
    int ia = (py - 1) * W + (px - 1);
    int ib = ia + 1;
    int ic = ia + W;
    int id = ic + 1;
    int a  = img[ia];
    int b  = img[ib];
    int cc = img[ic];
    int d  = img[id];
    int t;
    case (c)
      1: if (py > 1) py--;
      2: if (py < H - 1) py++;
      3: if (px > 1) px--;
      4: if (px < W - 1) px++;
      5, 6, 7: begin
        if (c == 5) begin
          t = a;
          if (b > t) t = b;
          if (cc > t) t = cc;
          if (d > t) t = d;
        end else if (c == 6) begin
          t = a;
          if (b < t) t = b;
          if (cc < t) t = cc;
          if (d < t) t = d;
        end else begin
          t = (a + b + cc + d) / 4;
        end
        img[ia] = t; img[ib] = t; img[ic] = t; img[id] = t;
      end
      8: begin img[ia] = b;  img[ib] = d; img[id] = cc; img[ic] = a; end
      9: begin img[ia] = cc; img[ic] = d; img[id] = b;  img[ib] = a; end
`ifdef IMG_WIN_CTRL_MIRROR_EN
      10: begin img[ia] = cc; img[ic] = a; img[ib] = d;  img[id] = b; end
      11: begin img[ia] = b;  img[ib] = a; img[ic] = d;  img[id] = cc; end
`endif
      default: ;
    endcase
  endtask

  // Present one command while idle; optionally strobe a junk command during EXEC.
  task automatic issue(input int c, input bit junk);
    int k = 0;
    while (busy !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("cmd_idle", busy, 0);
    cmd       = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("exec_busy", busy, 1);
    if (junk) begin
      cmd       = 4'($urandom_range(0, 15));
      cmd_valid = 1'b1;
    end else begin
      cmd_valid = 1'b0;
    end
    model_cmd(c);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (c != 0) check_eq("back_idle", busy, 0);
  endtask

  // Issue Write and compare the whole streamed image, then the FIN behaviour.
  task automatic do_write();
    issue(0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < N; i++) begin
      check_eq("wr_valid", IRAM_valid, 1);
      check_eq("wr_addr", IRAM_A, i);
      check_eq("wr_data", IRAM_D, img[i]);
      check_eq("wr_busy", busy, 1);
      got[i] = int'(IRAM_D);
      @(negedge clk);
    end
    check_eq("fin_done", done, 1);
    check_eq("fin_valid", IRAM_valid, 0);
    cmd       = 4'($urandom_range(0, 15));
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("fin_hold_done", done, 1);
    check_eq("fin_hold_busy", busy, 1);
    check_eq("fin_hold_valid", IRAM_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd       = '0;
    cmd_valid = 1'b0;

    // Identity image, immediate write.
    for (int i = 0; i < N; i++) rom[i] = 8'(i);
    do_load();
    do_write();
    check_eq("ident_5", got[5], 5);
    check_eq("ident_63", got[63], 63);

    // Shifts clamp at (1,1).
    do_load();
    repeat (5) issue(1, 1'b0);
    repeat (5) issue(3, 1'b0);
    do_write();
    check_eq("clamp_0", got[0], 0);
    check_eq("clamp_9", got[9], 9);

    // Window ops at (4,4), each from a fresh load.
    do_load();
    issue(7, 1'b0);
    do_write();
    check_eq("avg_27", got[27], 31);
    check_eq("avg_36", got[36], 31);
    do_load();
    issue(5, 1'b0);
    do_write();
    check_eq("max_28", got[28], 36);
    do_load();
    issue(6, 1'b0);
    do_write();
    check_eq("min_35", got[35], 27);
    do_load();
    issue(9, 1'b0);
    do_write();
    check_eq("cw_27", got[27], 35);
    check_eq("cw_28", got[28], 27);
    check_eq("cw_36", got[36], 28);
    check_eq("cw_35", got[35], 36);
    do_load();
    issue(10, 1'b0);
    do_write();
`ifdef IMG_WIN_CTRL_MIRROR_EN
    check_eq("mirx_27", got[27], 35);
    check_eq("mirx_36", got[36], 28);
`else
    check_eq("mirx_27", got[27], 27);
    check_eq("mirx_36", got[36], 36);
`endif

    // Saturated window: average must not wrap.
    for (int i = 0; i < N; i++) rom[i] = 8'hff;
    do_load();
    issue(7, 1'b0);
    do_write();
    check_eq("avg_255", got[27], 255);

    // Reset in the middle of the RAM write.
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
    do_load();
    issue(4, 1'b0);
    issue(2, 1'b0);
    issue(0, 1'b0);
    for (int i = 0; i < 20; i++) @(negedge clk);
    check_eq("mid_wr_addr", IRAM_A, 20);
    reset = 1'b1;
    do_load();
    issue(5, 1'b0);
    do_write();

    // Randomized command streams.
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
      do_load();
      repeat ($urandom_range(10, 40)) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        issue($urandom_range(1, 15), 1'($urandom_range(0, 1)));
      end
      do_write();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if something wedges despite the bounded waits.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
